// File: rtl/inst_fetch_mod_pkg.sv
// inst_fetch_mod_pkg
//   Shared definitions for the instruction fetch stage: FSM state encoding,
//   immediate-length codes, the default CB prefix byte and the helper that
//   picks the state following an opcode byte.
package inst_fetch_mod_pkg;

   typedef enum logic [2:0] {
      S_OP    = 3'd0,
      S_CB    = 3'd1,
      S_IMM1  = 3'd2,
      S_IMM2  = 3'd3,
      S_READY = 3'd4
   } fetch_state_e;

   typedef enum logic [1:0] {
      LEN_0 = 2'd0,
      LEN_1 = 2'd1,
      LEN_2 = 2'd2
   } imm_len_e;

   localparam logic [7:0] CB_PREFIX_DEFAULT = 8'hCB;

   // State entered after an opcode byte has been captured.
   function automatic fetch_state_e after_opcode(input logic [7:0] op,
                                                 input logic [7:0] cb_prefix,
                                                 input imm_len_e   len);
      if (op == cb_prefix)  return S_CB;
      else if (len == LEN_0) return S_READY;
      else                  return S_IMM1;
   endfunction

endpackage

// File: rtl/inst_fetch_mod_if.sv
// inst_fetch_mod_if
//   Byte-wide read bus between the fetch stage (master) and memory/arbiter (slave).
//   mem_addr    : byte address (master -> slave)
//   mem_rd      : read request (master -> slave)
//   mem_data_in : read data (slave -> master)
//   mem_ready   : read completes this cycle (slave -> master)
//   bus_grant   : bus released to the fetch stage (slave -> master)
interface inst_fetch_mod_if;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data_in;
   logic        mem_ready;
   logic        bus_grant;

   modport master (output mem_addr, mem_rd,
                   input  mem_data_in, mem_ready, bus_grant);
   modport slave  (input  mem_addr, mem_rd,
                   output mem_data_in, mem_ready, bus_grant);
endinterface

// File: rtl/inst_fetch_mod_len_decode.sv
// fetch_len_decode_mod
//   Combinational opcode -> immediate length (0/1/2 bytes) for unprefixed
//   opcodes. Unused opcodes fall into the length-0 default.
//   opcode  in  8  first instruction byte
//   imm_len out 2  number of immediate bytes that follow
module fetch_len_decode_mod
   import inst_fetch_mod_pkg::*;
(
   input  logic [7:0] opcode,
   output imm_len_e   imm_len
);

   always_comb begin
      imm_len = LEN_0;
      case (opcode)
         8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
         8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
         8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
         8'hE0, 8'hF0, 8'hE8, 8'hF8:
            imm_len = LEN_1;
         8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
         8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
         8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:
            imm_len = LEN_2;
         default:
            imm_len = LEN_0;
      endcase
   end

endmodule

// File: rtl/inst_fetch_mod.sv
// inst_fetch_mod
//   Instruction fetch stage: reads opcode / CB-prefix / immediate bytes at pc and
//   presents one whole instruction until the control unit retires it.
//   Optional feature macro: PREFETCH_EN (1-byte prefetch buffer filled in S_READY).
//   Ports:
//     clock, reset (async, active low)
//     bus           memory read bus (master modport)
//     pc_load/_value redirect of the program counter, highest priority
//     pc            address of next byte to fetch
//     inst_valid, inst_buffer, inst_cb, imm_lo, imm_hi  presented instruction
//     inst_ack      retires the presented instruction
//
//   state   | meaning
//   S_OP    | fetching opcode (or CB prefix) byte
//   S_CB    | fetching opcode byte after CB prefix
//   S_IMM1  | fetching low immediate byte
//   S_IMM2  | fetching high immediate byte
//   S_READY | instruction presented, waiting for inst_ack
module inst_fetch_mod
   import inst_fetch_mod_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [7:0]  CB_PREFIX = CB_PREFIX_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   inst_fetch_mod_if.master bus,
   input  logic             pc_load,
   input  logic [15:0]      pc_load_value,
   output logic [15:0]      pc,
   output logic             inst_valid,
   output logic [7:0]       inst_buffer,
   output logic             inst_cb,
   output logic [7:0]       imm_lo,
   output logic [7:0]       imm_hi,
   input  logic             inst_ack
);

   fetch_state_e state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic [7:0]   buf_q, buf_d, lo_q, lo_d, hi_q, hi_d;
   logic         cb_q, cb_d, valid_q, valid_d;
   imm_len_e     len_q, len_d, op_len;
   logic         rd_req, xfer, take_op;
   logic [7:0]   op_byte;
   logic [15:0]  pc_inc;

`ifdef PREFETCH_EN
   logic [7:0]   pf_q, pf_d;
   logic         pf_full_q, pf_full_d;

   // In S_READY the bus is only used while the prefetch buffer is empty.
   assign rd_req  = (state_q != S_READY) || !pf_full_q;
   assign op_byte = pf_full_q ? pf_q : bus.mem_data_in;
`else
   assign rd_req  = (state_q != S_READY);
   assign op_byte = bus.mem_data_in;
`endif

   // Gated by reset so no request leaves the block while it is held in reset.
   assign bus.mem_rd   = rd_req && bus.bus_grant && reset;
   assign bus.mem_addr = pc_q;
   assign xfer         = bus.mem_rd && bus.mem_ready;
   assign pc_inc       = pc_q + 16'd1;

   fetch_len_decode_mod u_len_decode (
      .opcode  (op_byte),
      .imm_len (op_len)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      buf_d   = buf_q;
      cb_d    = cb_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      len_d   = len_q;
      take_op = 1'b0;
`ifdef PREFETCH_EN
      pf_d      = pf_q;
      pf_full_d = pf_full_q;
`endif

      case (state_q)
         S_OP: begin
            if (xfer) take_op = 1'b1;
         end
         S_CB: begin
            if (xfer) begin
               buf_d   = bus.mem_data_in;
               cb_d    = 1'b1;
               pc_d    = pc_inc;
               state_d = S_READY;
            end
         end
         S_IMM1: begin
            if (xfer) begin
               lo_d    = bus.mem_data_in;
               pc_d    = pc_inc;
               state_d = (len_q == LEN_2) ? S_IMM2 : S_READY;
            end
         end
         S_IMM2: begin
            if (xfer) begin
               hi_d    = bus.mem_data_in;
               pc_d    = pc_inc;
               state_d = S_READY;
            end
         end
         S_READY: begin
`ifdef PREFETCH_EN
            // On ack the next opcode comes from the buffer, or straight off the
            // bus if it arrives in the ack cycle, so S_OP is skipped.
            if (inst_ack) begin
               if (pf_full_q || xfer) take_op = 1'b1;
               else                   state_d = S_OP;
               pf_full_d = 1'b0;
            end else if (xfer) begin
               pf_d      = bus.mem_data_in;
               pf_full_d = 1'b1;
               pc_d      = pc_inc;
            end
`else
            if (inst_ack) state_d = S_OP;
`endif
         end
         default: state_d = S_OP;
      endcase

      if (take_op) begin
         buf_d   = op_byte;
         cb_d    = 1'b0;
         lo_d    = 8'h00;
         hi_d    = 8'h00;
         len_d   = op_len;
         state_d = after_opcode(op_byte, CB_PREFIX, op_len);
`ifdef PREFETCH_EN
         if (!pf_full_q) pc_d = pc_inc;
`else
         pc_d = pc_inc;
`endif
      end

      if (pc_load) begin
         pc_d    = pc_load_value;
         state_d = S_OP;
`ifdef PREFETCH_EN
         pf_full_d = 1'b0;
`endif
      end

      valid_d = (state_d == S_READY);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_OP;
         pc_q      <= RESET_PC;
         buf_q     <= 8'h00;
         cb_q      <= 1'b0;
         lo_q      <= 8'h00;
         hi_q      <= 8'h00;
         len_q     <= LEN_0;
         valid_q   <= 1'b0;
`ifdef PREFETCH_EN
         pf_q      <= 8'h00;
         pf_full_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         buf_q     <= buf_d;
         cb_q      <= cb_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         len_q     <= len_d;
         valid_q   <= valid_d;
`ifdef PREFETCH_EN
         pf_q      <= pf_d;
         pf_full_q <= pf_full_d;
`endif
      end
   end

   assign pc          = pc_q;
   assign inst_valid  = valid_q;
   assign inst_buffer = buf_q;
   assign inst_cb     = cb_q;
   assign imm_lo      = lo_q;
   assign imm_hi      = hi_q;

endmodule

// File: tb/tb_inst_fetch_mod.sv
// tb_inst_fetch_mod
//   Bench for inst_fetch_mod: directed vector table, multi-cycle corner
//   sequences and a randomized run against an instruction-level memory model.
//   Honours PREFETCH_EN where the two builds differ.
module tb_inst_fetch_mod;

   logic        clock = 1'b0;
   logic        reset;
   logic        pc_load;
   logic [15:0] pc_load_value;
   logic [15:0] pc;
   logic        inst_valid;
   logic [7:0]  inst_buffer;
   logic        inst_cb;
   logic [7:0]  imm_lo;
   logic [7:0]  imm_hi;
   logic        inst_ack;

   logic [7:0]  mem [65536];

   int n_chk = 0;
   int n_pass = 0;
   int bus_viol = 0;

   always #5 clock = ~clock;

   inst_fetch_mod_if bus ();
   assign bus.mem_data_in = mem[bus.mem_addr];

   inst_fetch_mod #(.RESET_PC(16'h0000), .CB_PREFIX(8'hCB)) dut (
      .clock         (clock),
      .reset         (reset),
      .bus           (bus),
      .pc_load       (pc_load),
      .pc_load_value (pc_load_value),
      .pc            (pc),
      .inst_valid    (inst_valid),
      .inst_buffer   (inst_buffer),
      .inst_cb       (inst_cb),
      .imm_lo        (imm_lo),
      .imm_hi        (imm_hi),
      .inst_ack      (inst_ack)
   );

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  b0, b1, b2;
      logic [7:0]  e_buf;
      logic        e_cb;
      logic [7:0]  e_lo, e_hi;
      logic [15:0] e_pc;
      int          e_lat;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic jump_to(input logic [15:0] a, input logic ack);
      pc_load       = 1'b1;
      pc_load_value = a;
      inst_ack      = ack;
      tick();
      pc_load  = 1'b0;
      inst_ack = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int cyc);
      cyc = 0;
      while (!inst_valid && cyc < budget) begin
         tick();
         cyc++;
      end
      if (!inst_valid) check("valid_timeout", 32'(inst_valid), 32'd1);
   endtask

   // Immediate length by instruction family.
   function automatic int ref_len(input logic [7:0] op);
      if ((op[7:6] == 2'd0 && op[2:0] == 3'd6) ||          // LD r,d8
          op == 8'h10 || op == 8'h18 ||                   // STOP, JR
          (op[7:5] == 3'b001 && op[2:0] == 3'd0) ||        // JR cc
          (op[7:6] == 2'd3 && op[2:0] == 3'd6) ||          // ALU A,d8
          op == 8'hE0 || op == 8'hF0 || op == 8'hE8 || op == 8'hF8)
         return 1;
      if ((op[7:6] == 2'd0 && op[3:0] == 4'd1) ||          // LD rr,d16
          op == 8'h08 ||
          (op[7:5] == 3'b110 && (op[2:0] == 3'd2 || op[2:0] == 3'd4)) || // JP/CALL cc
          op == 8'hC3 || op == 8'hCD || op == 8'hEA || op == 8'hFA)
         return 2;
      return 0;
   endfunction

   // Bus rules sampled away from the active edge.
   always @(negedge clock) begin
      if (bus.mem_rd && (!bus.bus_grant || bus.mem_addr != pc)) bus_viol++;
      if (reset !== 1'b1 && bus.mem_rd) bus_viol++;
`ifndef PREFETCH_EN
      if (inst_valid && bus.mem_rd) bus_viol++;
`endif
   end

   initial begin
      int lat;
      logic [15:0] a;
      logic [15:0] model_pc;
      logic [7:0]  op, e_buf, e_lo, e_hi;
      logic        e_cb;
      int          nb;

      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      reset = 1'b0; pc_load = 1'b0; pc_load_value = 16'h0; inst_ack = 1'b0;
      bus.mem_ready = 1'b1; bus.bus_grant = 1'b1;

      // ---------------- reset state ----------------
      tick(); tick();
      check("rst_valid", 32'(inst_valid), 0);
      check("rst_buf",   32'(inst_buffer), 0);
      check("rst_cb",    32'(inst_cb), 0);
      check("rst_lo",    32'(imm_lo), 0);
      check("rst_hi",    32'(imm_hi), 0);
      check("rst_pc",    32'(pc), 0);
      check("rst_mem_rd", 32'(bus.mem_rd), 0);
      reset = 1'b1;
      wait_valid(20, lat);
      check("nop_lat", lat, 1);
      check("nop_buf", 32'(inst_buffer), 0);
      check("nop_pc",  32'(pc), 32'h0001);

      // ---------------- vector table ----------------
      vecs[0] = '{16'h0100, 8'h01, 8'h34, 8'h12, 8'h01, 1'b0, 8'h34, 8'h12, 16'h0103, 3};
      vecs[1] = '{16'h0200, 8'hCB, 8'h37, 8'h00, 8'h37, 1'b1, 8'h00, 8'h00, 16'h0202, 2};
      vecs[2] = '{16'hFFFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 16'h0000, 1};
      vecs[3] = '{16'h0300, 8'h3E, 8'h5A, 8'h00, 8'h3E, 1'b0, 8'h5A, 8'h00, 16'h0302, 2};
      vecs[4] = '{16'h0400, 8'hC3, 8'h00, 8'h80, 8'hC3, 1'b0, 8'h00, 8'h80, 16'h0403, 3};
      vecs[5] = '{16'h0500, 8'hD3, 8'h11, 8'h22, 8'hD3, 1'b0, 8'h00, 8'h00, 16'h0501, 1};
      vecs[6] = '{16'h0600, 8'hFE, 8'h10, 8'h00, 8'hFE, 1'b0, 8'h10, 8'h00, 16'h0602, 2};
      vecs[7] = '{16'hFFFE, 8'h18, 8'h05, 8'h00, 8'h18, 1'b0, 8'h05, 8'h00, 16'h0000, 2};
      vecs[8] = '{16'h0700, 8'hCB, 8'h01, 8'hFF, 8'h01, 1'b1, 8'h00, 8'h00, 16'h0702, 2};
      vecs[9] = '{16'h0800, 8'hE8, 8'hF0, 8'h00, 8'hE8, 1'b0, 8'hF0, 8'h00, 16'h0802, 2};

      for (int v = 0; v < 10; v++) begin
         a = vecs[v].addr;          mem[a] = vecs[v].b0;
         a = vecs[v].addr + 16'd1;  mem[a] = vecs[v].b1;
         a = vecs[v].addr + 16'd2;  mem[a] = vecs[v].b2;
         jump_to(vecs[v].addr, 1'b1);
         wait_valid(50, lat);
         check($sformatf("v%0d_lat", v), lat, vecs[v].e_lat);
         check($sformatf("v%0d_buf", v), 32'(inst_buffer), 32'(vecs[v].e_buf));
         check($sformatf("v%0d_cb",  v), 32'(inst_cb), 32'(vecs[v].e_cb));
         check($sformatf("v%0d_lo",  v), 32'(imm_lo), 32'(vecs[v].e_lo));
         check($sformatf("v%0d_hi",  v), 32'(imm_hi), 32'(vecs[v].e_hi));
         check($sformatf("v%0d_pc",  v), 32'(pc), 32'(vecs[v].e_pc));
      end

      // ---------------- stall mid-immediate ----------------
      mem[16'h0900] = 8'h11; mem[16'h0901] = 8'h78; mem[16'h0902] = 8'h56;
      jump_to(16'h0900, 1'b1);
      tick();   // opcode captured
      for (int i = 0; i < 4; i++) begin
         bus.mem_ready = (i == 3);
         bus.bus_grant = (i == 0 || i == 2);
         inst_ack = 1'b1;   // must be ignored while not valid
         #1;
         check($sformatf("stall%0d_rd", i), 32'(bus.mem_rd), 32'(bus.bus_grant));
         tick();
         check($sformatf("stall%0d_pc", i), 32'(pc), 32'h0901);
         check($sformatf("stall%0d_valid", i), 32'(inst_valid), 0);
      end
      inst_ack = 1'b0; bus.mem_ready = 1'b1; bus.bus_grant = 1'b1;
      wait_valid(20, lat);
      check("stall_lat", lat, 2);
      check("stall_buf", 32'(inst_buffer), 32'h11);
      check("stall_lo",  32'(imm_lo), 32'h78);
      check("stall_hi",  32'(imm_hi), 32'h56);
      check("stall_pc",  32'(pc), 32'h0903);

      // ---------------- redirect during S_IMM1 with ack ----------------
      mem[16'h0A00] = 8'h21; mem[16'h0A01] = 8'hAB; mem[16'h0A02] = 8'hCD;
      mem[16'h0150] = 8'h00;
      jump_to(16'h0A00, 1'b1);
      tick();   // in S_IMM1
      jump_to(16'h0150, 1'b1);
      check("redir_valid", 32'(inst_valid), 0);
      check("redir_addr",  32'(bus.mem_addr), 32'h0150);
      wait_valid(20, lat);
      check("redir_lat", lat, 1);
      check("redir_buf", 32'(inst_buffer), 32'h00);
      check("redir_lo",  32'(imm_lo), 32'h00);
      check("redir_pc",  32'(pc), 32'h0151);

      // ---------------- NOP stream, ack every valid cycle ----------------
      for (int i = 0; i < 8; i++) mem[16'h0B00 + 16'(i)] = 8'h00;
      jump_to(16'h0B00, 1'b1);
      wait_valid(20, lat);
      for (int k = 0; k < 3; k++) begin
         inst_ack = 1'b1;
         tick();
         inst_ack = 1'b0;
`ifdef PREFETCH_EN
         check($sformatf("stream%0d_valid", k), 32'(inst_valid), 1);
`else
         check($sformatf("stream%0d_gap", k), 32'(inst_valid), 0);
         tick();
         check($sformatf("stream%0d_valid", k), 32'(inst_valid), 1);
`endif
         check($sformatf("stream%0d_pc", k), 32'(pc), 32'(16'h0B02 + 16'(k)));
      end
      // One idle cycle in S_READY, then a jump must drop anything prefetched.
      mem[16'h0B04] = 8'h3E;
      tick();
`ifdef PREFETCH_EN
      check("idle_pc", 32'(pc), 32'h0B05);
`else
      check("idle_pc", 32'(pc), 32'h0B04);
`endif
      mem[16'h0C00] = 8'h00;
      jump_to(16'h0C00, 1'b1);
      wait_valid(20, lat);
      check("flush_lat", lat, 1);
      check("flush_buf", 32'(inst_buffer), 32'h00);
      check("flush_lo",  32'(imm_lo), 32'h00);
      check("flush_pc",  32'(pc), 32'h0C01);

      // ---------------- randomized run ----------------
      for (int i = 16'hD000; i < 16'hF000; i++) mem[i] = 8'($urandom);
      model_pc = 16'hD000;
      jump_to(model_pc, 1'b1);
      for (int n = 0; n < 120; n++) begin
         lat = 0;
         while (!inst_valid && lat < 300) begin
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            bus.bus_grant = ($urandom_range(0, 3) != 0);
            tick();
            lat++;
         end
         if (!inst_valid) check("rnd_timeout", 32'(inst_valid), 1);

         op = mem[model_pc];
         e_lo = 8'h00; e_hi = 8'h00;
         if (op == 8'hCB) begin
            e_buf = mem[model_pc + 16'd1]; e_cb = 1'b1; nb = 2;
         end else begin
            e_buf = op; e_cb = 1'b0; nb = 1 + ref_len(op);
            if (nb >= 2) e_lo = mem[model_pc + 16'd1];
            if (nb == 3) e_hi = mem[model_pc + 16'd2];
         end
         check($sformatf("rnd%0d_buf", n), 32'(inst_buffer), 32'(e_buf));
         check($sformatf("rnd%0d_cb",  n), 32'(inst_cb), 32'(e_cb));
         check($sformatf("rnd%0d_lo",  n), 32'(imm_lo), 32'(e_lo));
         check($sformatf("rnd%0d_hi",  n), 32'(imm_hi), 32'(e_hi));
         check($sformatf("rnd%0d_pc",  n), 32'(pc), 32'(model_pc + 16'(nb)));

         for (int h = $urandom_range(0, 3); h > 0; h--) begin
            bus.mem_ready = ($urandom_range(0, 1) != 0);
            bus.bus_grant = ($urandom_range(0, 1) != 0);
            tick();
         end
         if (h_hold_changed(e_buf)) check($sformatf("rnd%0d_hold", n), 32'(inst_buffer), 32'(e_buf));

         if ($urandom_range(0, 7) == 0) begin
            model_pc = 16'hD000 + 16'($urandom_range(0, 16'h0F00));
            jump_to(model_pc, 1'($urandom_range(0, 1)));
         end else begin
            inst_ack = 1'b1;
            tick();
            inst_ack = 1'b0;
            model_pc = model_pc + 16'(nb);
         end
      end

      check("bus_rules", 32'(bus_viol), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // After the hold cycles the instruction must still be presented unchanged.
   function automatic logic h_hold_changed(input logic [7:0] e);
      return (inst_valid !== 1'b1) || (inst_buffer !== e);
   endfunction

endmodule
